// File: rtl/filter_scheduler_pkg.sv
// Shared definitions for the filter scheduler.
//   sched_state_e : scheduler FSM state encoding
//   MemRw*        : memory bus command codes driven on mem_rw
package filter_scheduler_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StIssue    = 3'd1,
        StWaitFilt = 3'd2,
        StWrite    = 3'd3,
        StWaitWr   = 3'd4,
        StNext     = 3'd5,
        StDone     = 3'd6
    } sched_state_e;

    localparam logic [1:0] MemRwIdle  = 2'b00;
    localparam logic [1:0] MemRwRead  = 2'b01;
    localparam logic [1:0] MemRwWrite = 2'b10;

endpackage

// File: rtl/pixel_scan_counter.sv
// Row/column generator over the interior of an image (a margin of
// WINDOW_SIZE/2 pixels is skipped on every edge), row-major, col fastest.
//   clk, rst : clock, asynchronous active-low reset (row/col clear to 0)
//   load     : restart at the first interior pixel (M, M)
//   advance  : step to the next pixel, wrapping col to M and bumping row
//   row, col : current pixel coordinates
//   last     : current pixel is the final interior pixel
module pixel_scan_counter #(
    parameter int BUS_WIDTH   = 8,
    parameter int IMG_WIDTH   = 7,
    parameter int IMG_HEIGHT  = 7,
    parameter int WINDOW_SIZE = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 advance,
    output logic [BUS_WIDTH-1:0] row,
    output logic [BUS_WIDTH-1:0] col,
    output logic                 last
);

    localparam int                   Margin  = WINDOW_SIZE / 2;
    localparam logic [BUS_WIDTH-1:0] First   = BUS_WIDTH'(Margin);
    localparam logic [BUS_WIDTH-1:0] LastCol = BUS_WIDTH'(IMG_WIDTH - 1 - Margin);
    localparam logic [BUS_WIDTH-1:0] LastRow = BUS_WIDTH'(IMG_HEIGHT - 1 - Margin);
    localparam logic [BUS_WIDTH-1:0] One     = BUS_WIDTH'(1);

    logic [BUS_WIDTH-1:0] row_q, row_d;
    logic [BUS_WIDTH-1:0] col_q, col_d;
    logic                 last_col;

    always_comb begin
        last_col = (col_q == LastCol);
        row_d    = row_q;
        col_d    = col_q;
        if (load) begin
            row_d = First;
            col_d = First;
        end else if (advance) begin
            if (last_col) begin
                col_d = First;
                row_d = row_q + One;
            end else begin
                col_d = col_q + One;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = last_col && (row_q == LastRow);

endmodule

// File: rtl/filter_scheduler.sv
// Sequences a window filter over every interior pixel of an image and
// optionally writes each result back to memory at OUT_BASE.
// Optional feature: define FILTER_SCHED_WRITEBACK_EN to build the write-back
// path (WRITE/WAIT_WR states); otherwise results appear only on res_*.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   start, abort             : begin frame pulse / stop frame
//   busy, done               : frame in progress / one-cycle completion pulse
//   filt_en, s_row, s_col    : request to filter pixel (s_row, s_col)
//   filt_out, filt_rdy       : filter result and its valid strobe
//   filt_addr, filt_rw       : filter's memory request (passed through)
//   filt_drdy                : memory ready forwarded to the filter
//   mem_addr, mem_rw         : memory address / command (00 idle, 01 rd, 10 wr)
//   mem_idata, mem_drdy      : memory write data / memory ready
//   res_valid, res_data,
//   res_row, res_col         : one-cycle result strobe with data and position
module filter_scheduler
    import filter_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int BUS_WIDTH   = 8,
    parameter int IMG_WIDTH   = 7,
    parameter int IMG_HEIGHT  = 7,
    parameter int WINDOW_SIZE = 3,
    parameter int OUT_BASE    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  filt_en,
    output logic [BUS_WIDTH-1:0]  s_row,
    output logic [BUS_WIDTH-1:0]  s_col,
    input  logic [DATA_WIDTH-1:0] filt_out,
    input  logic                  filt_rdy,
    input  logic [BUS_WIDTH-1:0]  filt_addr,
    input  logic [1:0]            filt_rw,
    output logic                  filt_drdy,
    output logic [BUS_WIDTH-1:0]  mem_addr,
    output logic [1:0]            mem_rw,
    output logic [DATA_WIDTH-1:0] mem_idata,
    input  logic                  mem_drdy,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [BUS_WIDTH-1:0]  res_row,
    output logic [BUS_WIDTH-1:0]  res_col
);

    sched_state_e state_q, state_d;

    logic                  res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic [BUS_WIDTH-1:0]  res_row_q, res_row_d;
    logic [BUS_WIDTH-1:0]  res_col_q, res_col_d;

    logic                  cnt_load, cnt_adv, cnt_last;
    logic [BUS_WIDTH-1:0]  cnt_row, cnt_col;
    logic                  in_filt;
    logic [BUS_WIDTH-1:0]  wr_addr;

    pixel_scan_counter #(
        .BUS_WIDTH   (BUS_WIDTH),
        .IMG_WIDTH   (IMG_WIDTH),
        .IMG_HEIGHT  (IMG_HEIGHT),
        .WINDOW_SIZE (WINDOW_SIZE)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .advance (cnt_adv),
        .row     (cnt_row),
        .col     (cnt_col),
        .last    (cnt_last)
    );

    // Counter only advances in NEXT, so row/col still name the pixel being written.
    assign wr_addr = BUS_WIDTH'(OUT_BASE) + cnt_row * BUS_WIDTH'(IMG_WIDTH) + cnt_col;

`ifndef FILTER_SCHED_WRITEBACK_EN
    logic unused_wr_addr;
    assign unused_wr_addr = ^wr_addr;
`endif

    // Next-state logic; abort overrides everything (including a same-cycle
    // filt_rdy/mem_drdy) in any non-idle state.
    always_comb begin
        state_d     = state_q;
        cnt_load    = 1'b0;
        cnt_adv     = 1'b0;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_row_d   = res_row_q;
        res_col_d   = res_col_q;

        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d  = StIssue;
                        cnt_load = 1'b1;
                    end
                end
                StIssue: state_d = StWaitFilt;
                StWaitFilt: begin
                    if (filt_rdy) begin
                        res_valid_d = 1'b1;
                        res_data_d  = filt_out;
                        res_row_d   = cnt_row;
                        res_col_d   = cnt_col;
`ifdef FILTER_SCHED_WRITEBACK_EN
                        state_d     = StWrite;
`else
                        state_d     = StNext;
`endif
                    end
                end
`ifdef FILTER_SCHED_WRITEBACK_EN
                StWrite: state_d = StWaitWr;
                StWaitWr: begin
                    if (mem_drdy) begin
                        state_d = StNext;
                    end
                end
`endif
                StNext: begin
                    cnt_adv = 1'b1;
                    state_d = cnt_last ? StDone : StIssue;
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Output decode.
    always_comb begin
        in_filt   = (state_q == StIssue) || (state_q == StWaitFilt);
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        filt_en   = in_filt;
        s_row     = cnt_row;
        s_col     = cnt_col;
        filt_drdy = 1'b0;
        mem_addr  = '0;
        mem_rw    = MemRwIdle;
        mem_idata = '0;

        // While the filter is working it owns the memory bus.
        if (in_filt) begin
            mem_addr  = filt_addr;
            mem_rw    = filt_rw;
            filt_drdy = mem_drdy;
        end
`ifdef FILTER_SCHED_WRITEBACK_EN
        if ((state_q == StWrite) || (state_q == StWaitWr)) begin
            mem_addr  = wr_addr;
            mem_rw    = MemRwWrite;
            mem_idata = res_data_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_row_q   <= '0;
            res_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_row_q   <= res_row_d;
            res_col_q   <= res_col_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_row   = res_row_q;
    assign res_col   = res_col_q;

endmodule

// File: tb/tb_filter_scheduler.sv
// Directed bench for filter_scheduler on a 7x7 image with a 3x3 window.
// Covers both builds: the write-back checks are enabled when
// FILTER_SCHED_WRITEBACK_EN is defined.
module tb_filter_scheduler;

`ifdef FILTER_SCHED_WRITEBACK_EN
    localparam bit Wb = 1'b1;
`else
    localparam bit Wb = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic        busy, done, filt_en, filt_drdy, res_valid;
    logic [7:0]  s_row, s_col, mem_addr, res_row, res_col;
    logic [15:0] filt_out = '0, mem_idata, res_data;
    logic        filt_rdy = 1'b0, mem_drdy = 1'b0;
    logic [7:0]  filt_addr = '0;
    logic [1:0]  filt_rw = '0, mem_rw;

    int n_vec = 0, n_err = 0;
    int wr_cnt = 0, wr_cyc = 0, done_cnt = 0;

    filter_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .filt_en   (filt_en),
        .s_row     (s_row),
        .s_col     (s_col),
        .filt_out  (filt_out),
        .filt_rdy  (filt_rdy),
        .filt_addr (filt_addr),
        .filt_rw   (filt_rw),
        .filt_drdy (filt_drdy),
        .mem_addr  (mem_addr),
        .mem_rw    (mem_rw),
        .mem_idata (mem_idata),
        .mem_drdy  (mem_drdy),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_row   (res_row),
        .res_col   (res_col)
    );

    always #5 clk = ~clk;

    // Bus activity monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_rw == 2'b10) wr_cyc <= wr_cyc + 1;
        if (mem_rw == 2'b10 && mem_drdy) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_filt_en();
        int n = 0;
        while (filt_en !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("filt_en_rise", filt_en, 1);
    endtask

    // One full pixel: issue, filter result, optional write-back, next.
    task automatic do_pixel(input int r, input int c, input logic [15:0] val,
                            input int lat, input bit pulse_start);
        wait_filt_en();
        check("s_row", s_row, r);
        check("s_col", s_col, c);
        check("res_valid_low_in_issue", res_valid, 0);
        // filt_rdy raised already in ISSUE: must be ignored until WAIT_FILT.
        filt_out  = val;
        filt_rdy  = 1'b1;
        filt_addr = 8'(r * 7 + c);
        filt_rw   = 2'b01;
        mem_drdy  = 1'b1;
        start     = pulse_start;
        #1;
        check("pass_addr", mem_addr, r * 7 + c);
        check("pass_rw", mem_rw, 1);
        check("pass_drdy", filt_drdy, 1);
        tick();
        check("filt_en_hold", filt_en, 1);
        check("rdy_in_issue_ignored", res_valid, 0);
        check("s_col_hold", s_col, c);
        tick();
        check("res_valid", res_valid, 1);
        check("res_data", res_data, val);
        check("res_row", res_row, r);
        check("res_col", res_col, c);
        check("filt_en_drop", filt_en, 0);
        filt_rdy = 1'b0;
        start    = 1'b0;
        mem_drdy = 1'b0;
        filt_rw  = 2'b00;
`ifdef FILTER_SCHED_WRITEBACK_EN
        #1;
        check("wr_rw", mem_rw, 2);
        check("wr_addr", mem_addr, (64 + r * 7 + c) & 8'hff);
        check("wr_idata", mem_idata, val);
        check("wr_filt_drdy", filt_drdy, 0);
        tick();
        for (int i = 0; i < lat; i++) begin
            check("wait_wr_rw", mem_rw, 2);
            check("wait_wr_addr", mem_addr, (64 + r * 7 + c) & 8'hff);
            check("wait_wr_idata", mem_idata, val);
            tick();
        end
        mem_drdy = 1'b1;
        #1;
        check("wait_wr_filt_drdy", filt_drdy, 0);
        check("wait_wr_rw_last", mem_rw, 2);
        tick();
        mem_drdy = 1'b0;
        check("res_valid_one_cycle", res_valid, 0);
`endif
        // In NEXT: memory idle and mem_drdy not forwarded.
        mem_drdy = 1'b1;
        #1;
        check("next_rw", mem_rw, 0);
        check("next_filt_drdy", filt_drdy, 0);
        check("next_filt_en", filt_en, 0);
        mem_drdy = 1'b0;
    endtask

    task automatic frame_end();
        tick();
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
        tick();
        check("done_drop", done, 0);
        check("busy_after", busy, 0);
        check("filt_en_after", filt_en, 0);
    endtask

    initial begin
        int idx, lat, exp_cyc, d0, w0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_filt_en", filt_en, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_filt_drdy", filt_drdy, 0);
        check("rst_mem_rw", mem_rw, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_s_row", s_row, 0);
        rst = 1'b1;
        tick();

        // Frame A: ramp image (pixel = address), stray start mid-frame.
        start = 1'b1;
        tick();
        start   = 1'b0;
        idx     = 0;
        exp_cyc = 0;
        for (int r = 1; r <= 5; r++) begin
            for (int c = 1; c <= 5; c++) begin
                lat = (idx == 2) ? 3 : idx % 2;
                do_pixel(r, c, 16'(r * 7 + c), lat, idx == 2);
                exp_cyc += lat + 2;
                idx++;
            end
        end
        frame_end();
        check("frameA_done_cnt", done_cnt, 1);
        check("frameA_wr_cnt", wr_cnt, Wb ? 25 : 0);
        check("frameA_wr_cyc", wr_cyc, Wb ? exp_cyc : 0);

        // Frame B: abort during third pixel's WAIT_FILT, with filt_rdy high.
        d0 = done_cnt;
        w0 = wr_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        do_pixel(1, 1, 16'h0011, 0, 1'b0);
        do_pixel(1, 2, 16'h0022, 0, 1'b0);
        wait_filt_en();
        tick();
        check("abort_pre_filt_en", filt_en, 1);
        filt_out = 16'h0033;
        filt_rdy = 1'b1;
        mem_drdy = 1'b1;
        abort    = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_filt_en", filt_en, 0);
        check("abort_res_valid", res_valid, 0);
        check("abort_mem_rw", mem_rw, 0);
        check("abort_done", done, 0);
        abort    = 1'b0;
        filt_rdy = 1'b0;
        mem_drdy = 1'b0;
        repeat (3) tick();
        check("abort_no_done", done_cnt, d0);
        check("abort_no_write", wr_cnt, w0 + (Wb ? 2 : 0));
        check("abort_stays_idle", busy, 0);

        // Frame C: reset asserted mid-pixel (WAIT_WR or NEXT).
        start = 1'b1;
        tick();
        start    = 1'b0;
        filt_out = 16'h1234;
        filt_rdy = 1'b1;
        tick();
        tick();
        filt_rdy = 1'b0;
`ifdef FILTER_SCHED_WRITEBACK_EN
        tick();
        check("pre_rst_wait_wr", mem_rw, 2);
`endif
        mem_drdy = 1'b1;
        rst = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_filt_en", filt_en, 0);
        check("mrst_res_valid", res_valid, 0);
        check("mrst_filt_drdy", filt_drdy, 0);
        check("mrst_mem_rw", mem_rw, 0);
        check("mrst_mem_addr", mem_addr, 0);
        check("mrst_mem_idata", mem_idata, 0);
        check("mrst_res_data", res_data, 0);
        check("mrst_res_row", res_row, 0);
        check("mrst_res_col", res_col, 0);
        check("mrst_s_row", s_row, 0);
        check("mrst_s_col", s_col, 0);
        mem_drdy = 1'b0;
        #1;
        rst = 1'b1;
        tick();

        // Frame D: constant 0x0005 image after reset, restarts at (1,1).
        d0 = done_cnt;
        w0 = wr_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        idx   = 0;
        for (int r = 1; r <= 5; r++) begin
            for (int c = 1; c <= 5; c++) begin
                do_pixel(r, c, 16'h0005, (idx == 2) ? 3 : 0, 1'b0);
                idx++;
            end
        end
        frame_end();
        check("frameD_done_cnt", done_cnt, d0 + 1);
        check("frameD_wr_cnt", wr_cnt, w0 + (Wb ? 25 : 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
